hv_unshifter: RTL and testbench
===============================

Name: hv_unshifter

Overview:
Inverse-permutation unit for the sparse HDC datapath. `hv_shifter` applies a cyclic right rotation by SHIFT to a hypervector. This block undoes k such rotations. It accepts a hypervector that has been permuted k times plus the count k, and rotates it left by SHIFT once per enabled cycle, k times. Used on the query/decode side to recover level/position hypervectors from permuted bound vectors before similarity search.

Parameters:
HV_DIM, 1024, hypervector width in bits
SHIFT, 1, bits rotated per step; must equal the SHIFT of the matching hv_shifter; 1 <= SHIFT < HV_DIM
CNT_W, 11, width of shift_count; holds 0..2^CNT_W-1

Ports:
clk  input  1  clock, all state updates on rising edge
nrst  input  1  asynchronous active-low reset
en  input  1  global enable; when low, all state is frozen and no handshake completes
in_valid  input  1  perm_hv/shift_count are valid
in_ready  output  1  block can accept a new vector
perm_hv  input  HV_DIM  permuted hypervector (rho^k applied)
shift_count  input  CNT_W  k, the number of inverse steps to apply
out_valid  output  1  unshifted_hv holds the final result
out_ready  input  1  consumer accepts result
unshifted_hv  output  HV_DIM  working/result register; meaningful only while out_valid=1
busy  output  1  high in ROTATE or DONE

Behaviour:
- Reset (nrst=0, async): state=IDLE, working register=0, remaining counter=0, out_valid=0, busy=0. The same values apply whenever reset is asserted mid-operation; the in-flight vector is discarded.
- Rotation step: reg <= {reg[HV_DIM-SHIFT-1:0], reg[HV_DIM-1:HV_DIM-SHIFT]}. This is a left rotate by SHIFT and is the exact inverse of one hv_shifter step.
- in_ready = en && (state==IDLE). It is combinational from the registered state.
- out_valid = (state==DONE). busy = (state!=IDLE).
- No state changes on any edge where en=0, including counter, register and state.
- FSM:
  - IDLE: on en && in_valid, load reg<=perm_hv and rem<=shift_count. Go to DONE if shift_count==0, else go to ROTATE.
  - ROTATE: on each en cycle, apply one rotation step and set rem<=rem-1. When rem==1 at that edge, go to DONE.
  - DONE: hold reg. On en && out_ready, the transfer completes and the FSM goes to IDLE. reg keeps its value until the next load.
- Latency: the load edge is E0. out_valid rises after edge E0+k when en is held high, i.e. k+1 cycles from the cycle in which in_valid is sampled. For k=0, out_valid is high in the cycle after acceptance.
- Throughput: one vector per k+2 cycles at best. There is no accept in the same cycle as the output transfer; IDLE must be re-entered first.
- in_valid while busy is ignored (in_ready=0). The source must hold its data.
- Backpressure: DONE holds indefinitely with unshifted_hv stable while out_ready=0.
- k >= HV_DIM/SHIFT is legal. No modulo reduction is applied; the block performs all k steps, and the result equals a rotation by (k*SHIFT mod HV_DIM).
- No combinational path from perm_hv to unshifted_hv.

Test Plan:
- HV_DIM=16, SHIFT=1: perm_hv=16'h0001, k=3, en=1, out_ready=1 -> out_valid rises 4 cycles after the sampling cycle, unshifted_hv=16'h0008, high for 1 cycle, then in_ready=1.
- Round trip: hv_shifter output of 16'h0001 (=16'h8000), k=1 -> 16'h0001. perm_hv=16'hA5C3, k=0 -> 16'hA5C3 one cycle after accept.
- k=16 with HV_DIM=16, and k=17 -> results equal the input, and the input rotated left by 1, respectively. Check the latencies are 17 and 18 cycles.
- out_ready held low 5 cycles in DONE -> out_valid and unshifted_hv stable; in_valid pulses during this time are not accepted.
- en dropped for 3 cycles mid-ROTATE (k=4) -> the counter and register freeze. The result is unchanged (16'h0010 from 16'h0001) and out_valid is delayed by exactly 3 cycles.
- nrst pulsed low mid-ROTATE -> out_valid=0, busy=0 and unshifted_hv=0 immediately (asynchronous). The next accepted vector is processed correctly.

Source files
------------

// File: rtl/hv_unshifter.sv
// Inverse permutation for the sparse HDC datapath. It rotates a permuted hypervector
// left by SHIFT, once per enabled cycle, k times, and so undoes k hv_shifter steps.
module hv_unshifter #(
    parameter int unsigned HV_DIM = 1024,
    parameter int unsigned SHIFT  = 1,
    parameter int unsigned CNT_W  = 11
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [HV_DIM-1:0] perm_hv,
    input  logic [CNT_W-1:0]  shift_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [HV_DIM-1:0] unshifted_hv,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [HV_DIM-1:0]  hv;
    logic [CNT_W-1:0]   rem;
    logic               load;
    logic               rot;
    logic [HV_DIM-1:0]  hv_rotl;

    assign hv_rotl = {hv[HV_DIM-SHIFT-1:0], hv[HV_DIM-1:HV_DIM-SHIFT]};

    always_comb begin
        state_next = state;
        load       = 1'b0;
        rot        = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = (shift_count == '0) ? DONE : ROTATE;
                end
            end
            ROTATE: begin
                rot = 1'b1;
                if (rem == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // en gates every update so that a stalled pipeline freezes state, count and data together.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            hv    <= '0;
            rem   <= '0;
        end else if (en) begin
            state <= state_next;
            if (load) begin
                hv  <= perm_hv;
                rem <= shift_count;
            end else if (rot) begin
                hv  <= hv_rotl;
                rem <= rem - CNT_W'(1);
            end
        end
    end

    assign in_ready     = en && (state == IDLE);
    assign out_valid    = (state == DONE);
    assign busy         = (state != IDLE);
    assign unshifted_hv = hv;

endmodule

// File: tb/tb_hv_unshifter.sv
// Directed self-checking bench for hv_unshifter at HV_DIM=16, SHIFT=1.
module tb_hv_unshifter;

    localparam int HV_DIM = 16;
    localparam int SHIFT  = 1;
    localparam int CNT_W  = 11;

    logic              clk = 1'b0;
    logic              nrst;
    logic              en;
    logic              in_valid;
    logic              in_ready;
    logic [HV_DIM-1:0] perm_hv;
    logic [CNT_W-1:0]  shift_count;
    logic              out_valid;
    logic              out_ready;
    logic [HV_DIM-1:0] unshifted_hv;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hv_unshifter #(
        .HV_DIM(HV_DIM),
        .SHIFT (SHIFT),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .en          (en),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .perm_hv     (perm_hv),
        .shift_count (shift_count),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .unshifted_hv(unshifted_hv),
        .busy        (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input string tag, input logic [HV_DIM-1:0] hv, input int k);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_valid    = 1'b1;
        perm_hv     = hv;
        shift_count = CNT_W'(k);
        step();
        in_valid    = 1'b0;
        perm_hv     = ~hv;
        shift_count = '0;
    endtask

    // Counts edges from the acceptance edge until out_valid is seen.
    task automatic wait_out(input string tag, input int exp_lat);
        int lat;
        lat = 1;
        while (!out_valid && lat < 200) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic xfer(input string tag, input logic [HV_DIM-1:0] hv, input int k,
                        input logic [HV_DIM-1:0] exp_hv);
        send(tag, hv, k);
        wait_out(tag, k + 1);
        chk({tag, "_hv"}, 32'(unshifted_hv), 32'(exp_hv));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        step();
        chk({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        nrst        = 1'b0;
        en          = 1'b1;
        in_valid    = 1'b0;
        perm_hv     = '0;
        shift_count = '0;
        out_ready   = 1'b1;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hv", 32'(unshifted_hv), 32'd0);
        nrst = 1'b1;
        step();
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        xfer("k3", 16'h0001, 3, 16'h0008);
        xfer("roundtrip", 16'h8000, 1, 16'h0001);
        xfer("k0", 16'hA5C3, 0, 16'hA5C3);
        xfer("k16", 16'hA5C3, 16, 16'hA5C3);
        xfer("k17", 16'hA5C3, 17, 16'h4B87);

        // Backpressure: result held while out_ready is low, new inputs ignored.
        out_ready = 1'b0;
        send("bp", 16'h1234, 2);
        wait_out("bp", 3);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            perm_hv  = 16'hFFFF;
            chk("bp_ready", 32'(in_ready), 32'd0);
            step();
            chk("bp_ov", 32'(out_valid), 32'd1);
            chk("bp_hv", 32'(unshifted_hv), 32'h48D0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release", 32'(out_valid), 32'd0);
        chk("bp_busy", 32'(busy), 32'd0);
        chk("bp_hv_kept", 32'(unshifted_hv), 32'h48D0);

        // Enable dropped for 3 cycles after two rotations.
        send("en", 16'h0001, 4);
        step();
        step();
        chk("en_pre_hv", 32'(unshifted_hv), 32'h0004);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("en_frozen_hv", 32'(unshifted_hv), 32'h0004);
            chk("en_frozen_busy", 32'(busy), 32'd1);
            chk("en_frozen_ready", 32'(in_ready), 32'd0);
        end
        en = 1'b1;
        begin
            int lat;
            lat = 6;
            while (!out_valid && lat < 200) begin
                step();
                lat++;
            end
            chk("en_lat", 32'(lat), 32'd8);
        end
        chk("en_hv", 32'(unshifted_hv), 32'h0010);
        step();
        chk("en_done", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a rotation.
        send("rst", 16'h0001, 10);
        step();
        step();
        step();
        chk("rst_mid_busy_pre", 32'(busy), 32'd1);
        #2;
        nrst = 1'b0;
        #1;
        chk("rst_mid_ov", 32'(out_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_hv", 32'(unshifted_hv), 32'd0);
        nrst = 1'b1;
        step();
        xfer("after_rst", 16'hA5C3, 4, 16'h5C3A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
